fs_error_diffusion_core: RTL and testbench

//  Parametrised streaming Floyd-Steinberg core, successor to the fixed 256x256 1-bit gray path.

---
 rtl/fs_error_diffusion_core.sv | 154 +++++++++++++++
 tb/tb_fs_error_diffusion_core.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/fs_error_diffusion_core.sv
// fs_error_diffusion_core: streaming Floyd-Steinberg quantiser with ping-pong error line buffers.
module fs_error_diffusion_core #(
    parameter int IMAGEX     = 256,
    parameter int IMAGEY     = 256,
    parameter int RGB_SIZE   = 8,
    parameter int OUT_BITS   = 1,
    parameter int SERPENTINE = 0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [RGB_SIZE-1:0] s_data,
    input  logic                s_valid,
    output logic                s_ready,
    output logic [OUT_BITS-1:0] m_data,
    output logic                m_valid,
    input  logic                m_ready,
    output logic                m_last,
    output logic                busy,
    output logic                frame_done
);
    localparam int W  = RGB_SIZE;
    localparam int EW = W + 2;
    localparam int AW = W + 3;
    localparam int PW = EW + 3;
    localparam int L  = 2 ** OUT_BITS;
    localparam int XW = $clog2(IMAGEX);
    localparam int YW = (IMAGEY > 1) ? $clog2(IMAGEY) : 1;

    typedef enum logic [2:0] {IDLE, WAIT_PIX, CALC, EMIT, ROW_END, DONE} state_t;

    state_t state, nxt;
    logic [XW-1:0] x, x_back;
    logic [YW-1:0] y, y_nx;
    logic sel, fwd, first_col, last_col, y_last;
    logic [W-1:0] px, val;
    logic [OUT_BITS-1:0] q, q_r;
    logic signed [EW-1:0] ecur, e_right, pend_a, pend_b, err, e1, e3, e5, e7;
    logic signed [AW-1:0] acc;
    logic signed [PW-1:0] ew;
    logic signed [EW-1:0] buf0 [IMAGEX];
    logic signed [EW-1:0] buf1 [IMAGEX];

    function automatic logic [W-1:0] recon(input int k);
        logic [OUT_BITS-1:0] kb;
        logic [W-1:0] r;
        kb = OUT_BITS'(k);
        for (int i = 0; i < W; i++) r[W-1-i] = kb[OUT_BITS-1-(i % OUT_BITS)];
        return r;
    endfunction

    function automatic logic [W-1:0] thr(input int k);
        logic [W:0] s;
        s = {1'b0, recon(k - 1)} + {1'b0, recon(k)} + (W+1)'(1);
        return s[W:1];
    endfunction

    assign fwd       = !(SERPENTINE != 0 && y[0]);
    assign first_col = fwd ? (x == '0) : (x == XW'(IMAGEX - 1));
    assign last_col  = fwd ? (x == XW'(IMAGEX - 1)) : (x == '0);
    assign x_back    = fwd ? x - 1'b1 : x + 1'b1;
    assign y_last    = (y == YW'(IMAGEY - 1));
    assign y_nx      = y_last ? '0 : y + 1'b1;

    always_comb begin
        acc = AW'($signed({1'b0, px})) + AW'(e_right) + AW'(ecur);
        val = acc[AW-1] ? '0 : (|acc[AW-2:W]) ? '1 : acc[W-1:0];
        q = '0;
        for (int k = 1; k < L; k++) if (val >= thr(k)) q = q + OUT_BITS'(1);
        err = $signed({2'b00, val}) - $signed({2'b00, recon(int'(q))});
        ew = PW'(err);
        e1 = err >>> 4;
        e3 = EW'((ew + (ew <<< 1)) >>> 4);
        e5 = EW'((ew + (ew <<< 2)) >>> 4);
        e7 = err - e1 - e3 - e5;
    end

    always_ff @(posedge clk or negedge rst)
        if (!rst) state <= IDLE;
        else state <= nxt;

    always_comb begin
        nxt = state;
        case (state)
            IDLE:     if (start) nxt = WAIT_PIX;
            WAIT_PIX: if (s_valid) nxt = CALC;
            CALC:     nxt = EMIT;
            EMIT:     if (m_ready) nxt = last_col ? ROW_END : WAIT_PIX;
            ROW_END:  nxt = y_last ? DONE : WAIT_PIX;
            default:  nxt = IDLE;
        endcase
        s_ready    = (state == WAIT_PIX);
        m_valid    = (state == EMIT);
        m_data     = m_valid ? q_r : '0;
        m_last     = m_valid && y_last && last_col;
        busy       = (state != IDLE);
        frame_done = (state == DONE);
    end

    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            x <= '0;
            y <= '0;
            sel <= 1'b0;
            px <= '0;
            ecur <= '0;
            e_right <= '0;
            pend_a <= '0;
            pend_b <= '0;
            q_r <= '0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    x <= '0;
                    y <= '0;
                    e_right <= '0;
                    pend_a <= '0;
                    pend_b <= '0;
                end
                WAIT_PIX: if (s_valid) begin
                    px <= s_data;
                    ecur <= (y == '0) ? '0 : (sel ? buf1[x] : buf0[x]);
                end
                CALC: begin
                    q_r <= q;
                    e_right <= e7;
                    pend_a <= pend_b + e5;
                    pend_b <= e1;
                end
                EMIT: if (m_ready && !last_col) x <= fwd ? x + 1'b1 : x - 1'b1;
                ROW_END: begin
                    e_right <= '0;
                    pend_a <= '0;
                    pend_b <= '0;
                    sel <= ~sel;
                    y <= y_nx;
                    x <= (SERPENTINE != 0 && y_nx[0]) ? XW'(IMAGEX - 1) : '0;
                end
                default: ;
            endcase
        end

    // err_nxt is whichever buffer is not being read this row
    always_ff @(posedge clk) begin
        if (state == CALC && !first_col) begin
            if (sel) buf0[x_back] <= pend_a + e3;
            else buf1[x_back] <= pend_a + e3;
        end
        if (state == ROW_END) begin
            if (sel) buf0[x] <= pend_a;
            else buf1[x] <= pend_a;
        end
    end
endmodule

// File: tb/tb_fs_error_diffusion_core.sv
// tb_fs_error_diffusion_core: random frames on two core configurations checked against a whole-image FS model.
module tb_fs_error_diffusion_core;
    logic clk = 1'b0;
    logic rst_s [2];
    logic start_s [2];
    logic s_valid_s [2];
    logic m_ready_s [2];
    logic [7:0] s_data_s [2];
    logic s_rdy [2];
    logic m_vld [2];
    logic m_lst [2];
    logic bsy [2];
    logic fdone [2];
    logic [0:0] md_a;
    logic [1:0] md_b;
    int vectors = 0;
    int errors = 0;
    int pix [64];
    int expq [64];
    int got [64];

    always #5 clk = ~clk;

    fs_error_diffusion_core #(.IMAGEX(4), .IMAGEY(2), .RGB_SIZE(8), .OUT_BITS(1), .SERPENTINE(0)) dut_a (
        .clk(clk), .rst(rst_s[0]), .start(start_s[0]), .s_data(s_data_s[0]), .s_valid(s_valid_s[0]),
        .s_ready(s_rdy[0]), .m_data(md_a), .m_valid(m_vld[0]), .m_ready(m_ready_s[0]), .m_last(m_lst[0]),
        .busy(bsy[0]), .frame_done(fdone[0]));

    fs_error_diffusion_core #(.IMAGEX(5), .IMAGEY(3), .RGB_SIZE(8), .OUT_BITS(2), .SERPENTINE(1)) dut_b (
        .clk(clk), .rst(rst_s[1]), .start(start_s[1]), .s_data(s_data_s[1]), .s_valid(s_valid_s[1]),
        .s_ready(s_rdy[1]), .m_data(md_b), .m_valid(m_vld[1]), .m_ready(m_ready_s[1]), .m_last(m_lst[1]),
        .busy(bsy[1]), .frame_done(fdone[1]));

    function automatic int cx(input int idx); return idx != 0 ? 5 : 4; endfunction
    function automatic int cy(input int idx); return idx != 0 ? 3 : 2; endfunction
    function automatic int cob(input int idx); return idx != 0 ? 2 : 1; endfunction
    function automatic int cserp(input int idx); return idx; endfunction
    function automatic int mdat(input int idx); return idx != 0 ? int'(md_b) : int'(md_a); endfunction

    task automatic chk(input string tag, input int got_v, input int exp_v);
        vectors++;
        if (got_v != exp_v) begin
            errors++;
            $display("FAIL %s got=%0d expected=%0d", tag, got_v, exp_v);
        end
    endtask

    // Whole-frame reference: error image in image coordinates, expected indices in scan order.
    function automatic void model(input int idx);
        int nx, ny, lv, dir, x, acc, q, err, e1, e3, e5, e7;
        int e [64];
        nx = cx(idx);
        ny = cy(idx);
        lv = (1 << cob(idx)) - 1;
        for (int i = 0; i < 64; i++) e[i] = 0;
        for (int y = 0; y < ny; y++) begin
            dir = (cserp(idx) != 0 && y % 2 == 1) ? -1 : 1;
            for (int j = 0; j < nx; j++) begin
                x = dir > 0 ? j : nx - 1 - j;
                acc = pix[y*nx+x] + e[y*nx+x];
                acc = acc < 0 ? 0 : acc > 255 ? 255 : acc;
                q = 0;
                for (int k = 1; k <= lv; k++)
                    if (acc >= ((k - 1) * 255 / lv + k * 255 / lv + 1) / 2) q++;
                err = acc - q * 255 / lv;
                e1 = err >>> 4;
                e3 = (err * 3) >>> 4;
                e5 = (err * 5) >>> 4;
                e7 = err - e1 - e3 - e5;
                if (x + dir >= 0 && x + dir < nx) e[y*nx+x+dir] += e7;
                if (y + 1 < ny) begin
                    if (x - dir >= 0 && x - dir < nx) e[(y+1)*nx+x-dir] += e3;
                    e[(y+1)*nx+x] += e5;
                    if (x + dir >= 0 && x + dir < nx) e[(y+1)*nx+x+dir] += e1;
                end
                expq[y*nx+j] = q;
            end
        end
    endfunction

    task automatic fill(input int n, input int v);
        int r;
        for (int i = 0; i < n; i++) begin
            r = int'($urandom_range(3, 0));
            pix[i] = v >= 0 ? v : r == 0 ? 0 : r == 1 ? 255 : int'($urandom_range(255, 0));
        end
    endtask

    task automatic run_frame(input int idx, input int lo, input int hi, input int stop_after);
        int nx, ny, n, y, j, x, d0, st, fd;
        nx = cx(idx);
        ny = cy(idx);
        model(idx);
        start_s[idx] = 1'b1;
        @(posedge clk); #1;
        start_s[idx] = 1'b0;
        chk("busy_start", int'(bsy[idx]), 1);
        for (int i = 0; i < nx * ny; i++) begin
            if (i == stop_after) return;
            repeat ($urandom_range(1, 0)) begin @(posedge clk); #1; end
            y = i / nx;
            j = i % nx;
            x = (cserp(idx) != 0 && y % 2 == 1) ? nx - 1 - j : j;
            s_data_s[idx] = 8'(pix[y*nx+x]);
            s_valid_s[idx] = 1'b1;
            n = 0;
            while (!s_rdy[idx] && n < 50) begin @(posedge clk); #1; n++; end
            chk("accept", int'(s_rdy[idx]), 1);
            @(posedge clk); #1;
            s_valid_s[idx] = 1'b0;
            n = 0;
            while (!m_vld[idx] && n < 20) begin @(posedge clk); #1; n++; end
            chk("latency", n, 1);
            d0 = mdat(idx);
            st = int'($urandom_range(hi, lo));
            for (int k = 0; k < st; k++) begin
                @(posedge clk); #1;
                chk("hold_data", mdat(idx), d0);
                chk("hold_srdy", int'(s_rdy[idx]), 0);
                chk("hold_valid", int'(m_vld[idx]), 1);
            end
            got[i] = mdat(idx);
            chk("q", got[i], expq[i]);
            chk("last", int'(m_lst[idx]), int'(i == nx * ny - 1));
            m_ready_s[idx] = 1'b1;
            @(posedge clk); #1;
            m_ready_s[idx] = 1'b0;
        end
        fd = 0;
        repeat (6) begin fd += int'(fdone[idx]); @(posedge clk); #1; end
        chk("frame_done", fd, 1);
        chk("busy_end", int'(bsy[idx]), 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int s;
        for (int i = 0; i < 2; i++) begin
            rst_s[i] = 1'b0;
            start_s[i] = 1'b0;
            s_valid_s[i] = 1'b0;
            m_ready_s[i] = 1'b0;
            s_data_s[i] = '0;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            chk("rst_busy", int'(bsy[i]), 0);
            chk("rst_srdy", int'(s_rdy[i]), 0);
            chk("rst_mvalid", int'(m_vld[i]), 0);
            chk("rst_mdata", mdat(i), 0);
            chk("rst_mlast", int'(m_lst[i]), 0);
            chk("rst_done", int'(fdone[i]), 0);
            rst_s[i] = 1'b1;
        end
        @(posedge clk); #1;

        fill(8, 0);
        run_frame(0, 0, 0, -1);
        s = 0;
        for (int i = 0; i < 8; i++) s += got[i];
        chk("zeros_sum", s, 0);
        fill(8, 255);
        run_frame(0, 0, 2, -1);
        s = 0;
        for (int i = 0; i < 8; i++) s += got[i];
        chk("full_sum", s, 8);
        fill(8, 128);
        run_frame(0, 0, 1, -1);
        chk("mid_px0", got[0], 1);
        chk("mid_px1", got[1], 0);
        fill(8, -1);
        run_frame(0, 10, 10, -1);
        repeat (4) begin fill(8, -1); run_frame(0, 0, 3, -1); end

        fill(8, -1);
        run_frame(0, 0, 1, 5);
        chk("mid_busy", int'(bsy[0]), 1);
        rst_s[0] = 1'b0;
        #1;
        chk("mid_rst_busy", int'(bsy[0]), 0);
        chk("mid_rst_srdy", int'(s_rdy[0]), 0);
        chk("mid_rst_mvalid", int'(m_vld[0]), 0);
        chk("mid_rst_done", int'(fdone[0]), 0);
        repeat (2) @(posedge clk);
        #1;
        rst_s[0] = 1'b1;
        @(posedge clk); #1;
        run_frame(0, 0, 1, -1);

        fill(15, 'h60);
        run_frame(1, 0, 1, -1);
        chk("ob2_px0", got[0], 1);
        repeat (5) begin fill(15, -1); run_frame(1, 0, 3, -1); end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
